// File: rtl/wb_prefetch_pkg.sv
// Shared types and constants for the Wishbone instruction prefetcher.
// Holds the fetch FSM states and the buffered FIFO entry layout.
package wb_prefetch_pkg;

    localparam int INS_W = 32;
    localparam logic [3:0] WB_SEL_ALL = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        GAP,
        DRAIN
    } state_e;

    typedef struct packed {
        logic             err;
        logic [31:0]      adr;
        logic [INS_W-1:0] dat;
    } fifo_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// Small synchronous FIFO of fetched instruction words.
// Head is read straight from storage and forced to zero when empty.
module prefetch_fifo
    import wb_prefetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  fifo_entry_t            din_i,
    output fifo_entry_t            dout_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o,
    output logic                   full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0] CNT_ONE = 1;
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    fifo_entry_t   mem_q [DEPTH];
    logic [AW-1:0] rd_q;
    logic [AW-1:0] wr_q;
    logic [AW:0]   cnt_q;
    logic          push_ok;
    logic          pop_ok;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CNT_FULL);
    assign count_o = cnt_q;
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);
    assign dout_o  = empty_o ? '0 : mem_q[rd_q];

    // Storage array: written on every accepted push.
    always_ff @(posedge clk) begin
        if (push_ok && !flush_i) begin
            mem_q[wr_q] <= din_i;
        end
    end

    // Pointers and occupancy; flush empties the queue outright.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) begin
                wr_q <= wr_q + PTR_ONE;
            end
            if (pop_ok) begin
                rd_q <= rd_q + PTR_ONE;
            end
            if (push_ok && !pop_ok) begin
                cnt_q <= cnt_q + CNT_ONE;
            end else if (pop_ok && !push_ok) begin
                cnt_q <= cnt_q - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/wb_prefetch.sv
// Wishbone classic read master streaming sequential words into a FIFO.
// One idle bus cycle separates transfers; redirects flush everything.
module wb_prefetch
    import wb_prefetch_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] RESET_ADR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_i,
    input  logic [31:0] redirect_adr_i,
    output logic [31:0] ins_o,
    output logic [31:0] ins_adr_o,
    output logic        ins_err_o,
    output logic        ins_valid_o,
    input  logic        ins_ready_i,
    output logic [31:0] wb_adr_o,
    input  logic [31:0] wb_dat_i,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_e        state_q, state_d;
    logic [31:0]   ptr_q, ptr_d;
    logic [31:0]   adr_q, adr_d;
    logic          push;
    logic          term;
    logic          has_credit;
    logic [31:0]   new_adr;
    logic [31:0]   fetch_adr;
    logic [CW-1:0] fifo_cnt;
    logic [CW-1:0] credit;
    logic          fifo_empty;
    logic          fifo_full;
    fifo_entry_t   fifo_din;
    fifo_entry_t   fifo_head;

    assign term      = wb_ack_i || wb_err_i;
    assign new_adr   = redirect_adr_i & 32'hFFFF_FFFC;
    assign fetch_adr = redirect_i ? new_adr : ptr_q;
    // Registered occupancy only: a pop this cycle frees space next cycle.
    assign credit     = CW'(DEPTH) - fifo_cnt;
    assign has_credit = (credit != '0);

    assign wb_cyc_o = (state_q == REQ) || (state_q == DRAIN);
    assign wb_stb_o = wb_cyc_o;
    assign wb_adr_o = adr_q;
    assign wb_we_o  = 1'b0;
    assign wb_sel_o = WB_SEL_ALL;

    assign ins_o       = fifo_head.dat;
    assign ins_adr_o   = fifo_head.adr;
    assign ins_err_o   = fifo_head.err;
    assign ins_valid_o = !fifo_empty;

    // Error-terminated words carry a zero payload.
    always_comb begin
        fifo_din     = '0;
        fifo_din.err = wb_err_i;
        fifo_din.adr = adr_q;
        fifo_din.dat = wb_err_i ? '0 : wb_dat_i;
    end

    // Fetch FSM: GAP may issue straight away so back-to-back words
    // see exactly one low cycle of stb between them.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        adr_d   = adr_q;
        push    = 1'b0;
        if (redirect_i) begin
            ptr_d = new_adr;
        end
        unique case (state_q)
            IDLE, GAP: begin
                if (redirect_i || has_credit) begin
                    state_d = REQ;
                    adr_d   = fetch_adr;
                    ptr_d   = fetch_adr;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (term) begin
                    state_d = GAP;
                    if (!redirect_i) begin
                        push  = !fifo_full;
                        ptr_d = adr_q + 32'd4;
                    end
                end else if (redirect_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (term) begin
                    state_d = GAP;
                end
            end
        endcase
    end

    // FSM, fetch pointer and bus address registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= RESET_ADR;
            adr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            adr_q   <= adr_d;
        end
    end

    prefetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (push),
        .pop_i  (ins_ready_i),
        .flush_i(redirect_i),
        .din_i  (fifo_din),
        .dout_o (fifo_head),
        .count_o(fifo_cnt),
        .empty_o(fifo_empty),
        .full_o (fifo_full)
    );

endmodule

// File: tb/tb_wb_prefetch.sv
// Bench for wb_prefetch: ROM slave returning word = address,
// scoreboard of expected words popped against the FIFO head.
module tb_wb_prefetch;

    typedef struct packed {
        logic        err;
        logic [31:0] adr;
        logic [31:0] dat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_adr_i = '0;
    logic        ins_ready_i = 1'b0;
    logic [31:0] ins_o;
    logic [31:0] ins_adr_o;
    logic        ins_err_o;
    logic        ins_valid_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_i;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_ack_i;
    logic        wb_err_i;

    int          checks = 0;
    int          passed = 0;
    int          lat = 0;
    int          wcnt;
    logic        err_en = 1'b0;
    logic [31:0] err_adr = '0;

    exp_t        q[$];
    logic [31:0] req_log[$];
    logic [31:0] exp_ptr;
    bit          drain;
    logic        cyc_prev;

    always #5 clk = ~clk;

    wb_prefetch #(
        .DEPTH    (4),
        .RESET_ADR(32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .redirect_i    (redirect_i),
        .redirect_adr_i(redirect_adr_i),
        .ins_o         (ins_o),
        .ins_adr_o     (ins_adr_o),
        .ins_err_o     (ins_err_o),
        .ins_valid_o   (ins_valid_o),
        .ins_ready_i   (ins_ready_i),
        .wb_adr_o      (wb_adr_o),
        .wb_dat_i      (wb_dat_i),
        .wb_cyc_o      (wb_cyc_o),
        .wb_stb_o      (wb_stb_o),
        .wb_we_o       (wb_we_o),
        .wb_sel_o      (wb_sel_o),
        .wb_ack_i      (wb_ack_i),
        .wb_err_i      (wb_err_i)
    );

    // ROM slave: word equals its address, ack/err after lat wait cycles.
    assign wb_dat_i = wb_adr_o;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_ack_i <= 1'b0;
            wb_err_i <= 1'b0;
            wcnt     <= 0;
        end else if (wb_cyc_o && wb_stb_o && !wb_ack_i && !wb_err_i) begin
            if (wcnt >= lat) begin
                if (err_en && wb_adr_o == err_adr) wb_err_i <= 1'b1;
                else wb_ack_i <= 1'b1;
                wcnt <= 0;
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            wb_ack_i <= 1'b0;
            wb_err_i <= 1'b0;
        end
    end

    // Scoreboard: push on bus termination, pop-compare on handshake.
    always @(negedge clk) begin
        exp_t e;
        bit   exp_v;
        if (!rst_n) begin
            q.delete();
            drain    = 1'b0;
            cyc_prev = 1'b0;
            exp_ptr  = 32'h0;
        end else begin
            exp_v = (q.size() != 0);
            checks++;
            if (ins_valid_o !== exp_v)
                $display("FAIL occupancy: ins_valid_o=%b expected %b",
                         ins_valid_o, exp_v);
            else passed++;
            if (ins_valid_o && ins_ready_i && !redirect_i && q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if ({ins_err_o, ins_adr_o, ins_o} !== e)
                    $display("FAIL pop: got err=%b adr=%h ins=%h, expected err=%b adr=%h ins=%h",
                             ins_err_o, ins_adr_o, ins_o, e.err, e.adr, e.dat);
                else passed++;
            end
            if (wb_cyc_o && !cyc_prev) req_log.push_back(wb_adr_o);
            cyc_prev = wb_cyc_o;
            if (redirect_i) begin
                q.delete();
                drain   = wb_cyc_o && !(wb_ack_i || wb_err_i);
                exp_ptr = redirect_adr_i & 32'hFFFF_FFFC;
            end else if (wb_cyc_o && (wb_ack_i || wb_err_i)) begin
                if (drain) begin
                    drain = 1'b0;
                end else begin
                    checks++;
                    if (wb_adr_o !== exp_ptr)
                        $display("FAIL bus_adr: got %h, expected %h",
                                 wb_adr_o, exp_ptr);
                    else passed++;
                    e.err = wb_err_i;
                    e.adr = exp_ptr;
                    e.dat = wb_err_i ? 32'h0 : exp_ptr;
                    q.push_back(e);
                    exp_ptr = exp_ptr + 32'd4;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves the bench just before the first clock edge after release.
    task automatic do_reset();
        rst_n       = 1'b0;
        redirect_i  = 1'b0;
        ins_ready_i = 1'b0;
        lat         = 0;
        err_en      = 1'b0;
        repeat (2) @(negedge clk);
        req_log.delete();
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o} !== {3'b000, 4'hF, 32'h0})
            $display("FAIL reset_bus: cyc=%b stb=%b we=%b sel=%h adr=%h, expected 0 0 0 f 0",
                     wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o);
        else passed++;
        checks++;
        if ({ins_valid_o, ins_err_o, ins_o, ins_adr_o} !== 66'h0)
            $display("FAIL reset_ins: valid=%b err=%b ins=%h adr=%h, expected all 0",
                     ins_valid_o, ins_err_o, ins_o, ins_adr_o);
        else passed++;
    endtask

    task automatic test_stream();
        logic        exp_stb;
        logic [31:0] exp_ins;
        do_reset();
        ins_ready_i = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step(1);
            exp_stb = (i % 3 != 2);
            checks++;
            if ({wb_cyc_o, wb_stb_o} !== {exp_stb, exp_stb})
                $display("FAIL stream_stb c%0d: cyc=%b stb=%b, expected %b",
                         i, wb_cyc_o, wb_stb_o, exp_stb);
            else passed++;
            if (i % 3 == 2) begin
                exp_ins = 32'(i / 3) * 32'd4;
                checks++;
                if (!ins_valid_o || ins_o !== exp_ins)
                    $display("FAIL stream_ins c%0d: valid=%b ins=%h, expected 1 %h",
                             i, ins_valid_o, ins_o, exp_ins);
                else passed++;
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (req_log.size() <= i || req_log[i] !== 32'(i) * 32'd4)
                $display("FAIL stream_req%0d: got %h, expected %h", i,
                         (req_log.size() > i) ? req_log[i] : 32'hx, 32'(i) * 32'd4);
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        step(30);
        checks++;
        if (req_log.size() != 4)
            $display("FAIL bp_count: got %0d requests, expected 4", req_log.size());
        else passed++;
        for (int i = 0; i < 4 && i < req_log.size(); i++) begin
            checks++;
            if (req_log[i] !== 32'(i) * 32'd4)
                $display("FAIL bp_req%0d: got %h, expected %h", i, req_log[i], 32'(i) * 32'd4);
            else passed++;
        end
        checks++;
        if (wb_cyc_o !== 1'b0)
            $display("FAIL bp_idle: cyc=%b, expected 0", wb_cyc_o);
        else passed++;
        ins_ready_i = 1'b1;
        step(12);
        checks++;
        if (req_log.size() < 5 || req_log[4] !== 32'h10)
            $display("FAIL bp_resume: got %h, expected 00000010",
                     (req_log.size() > 4) ? req_log[4] : 32'hx);
        else passed++;
    endtask

    task automatic test_redirect_req();
        int n;
        do_reset();
        ins_ready_i = 1'b1;
        lat = 3;
        step(2);
        checks++;
        if (wb_cyc_o !== 1'b1 || wb_ack_i !== 1'b0)
            $display("FAIL rdq_setup: cyc=%b ack=%b, expected 1 0", wb_cyc_o, wb_ack_i);
        else passed++;
        redirect_adr_i = 32'h0000_1003;
        redirect_i = 1'b1;
        step(1);
        redirect_i = 1'b0;
        checks++;
        if (ins_valid_o !== 1'b0 || wb_cyc_o !== 1'b1)
            $display("FAIL rdq_flush: valid=%b cyc=%b, expected 0 1", ins_valid_o, wb_cyc_o);
        else passed++;
        for (n = 0; n < 30 && req_log.size() < 2; n++) step(1);
        checks++;
        if (req_log.size() < 2 || req_log[1] !== 32'h1000)
            $display("FAIL rdq_adr: got %h, expected 00001000",
                     (req_log.size() > 1) ? req_log[1] : 32'hx);
        else passed++;
        for (n = 0; n < 30 && !ins_valid_o; n++) step(1);
        checks++;
        if (!ins_valid_o || ins_adr_o !== 32'h1000)
            $display("FAIL rdq_first: valid=%b adr=%h, expected 1 00001000",
                     ins_valid_o, ins_adr_o);
        else passed++;
        step(6);
    endtask

    task automatic test_redirect_ack_pop();
        do_reset();
        step(5);
        checks++;
        if (wb_ack_i !== 1'b1 || ins_valid_o !== 1'b1)
            $display("FAIL rda_setup: ack=%b valid=%b, expected 1 1", wb_ack_i, ins_valid_o);
        else passed++;
        ins_ready_i = 1'b1;
        redirect_adr_i = 32'h0000_2000;
        redirect_i = 1'b1;
        step(1);
        redirect_i = 1'b0;
        checks++;
        if (ins_valid_o !== 1'b0 || wb_cyc_o !== 1'b0)
            $display("FAIL rda_flush: valid=%b cyc=%b, expected 0 0", ins_valid_o, wb_cyc_o);
        else passed++;
        step(1);
        checks++;
        if (wb_cyc_o !== 1'b1 || wb_adr_o !== 32'h2000)
            $display("FAIL rda_req: cyc=%b adr=%h, expected 1 00002000", wb_cyc_o, wb_adr_o);
        else passed++;
        for (int n = 0; n < 20 && !ins_valid_o; n++) step(1);
        checks++;
        if (!ins_valid_o || ins_adr_o !== 32'h2000)
            $display("FAIL rda_first: valid=%b adr=%h, expected 1 00002000",
                     ins_valid_o, ins_adr_o);
        else passed++;
        step(10);
    endtask

    task automatic test_err();
        int n;
        do_reset();
        ins_ready_i = 1'b1;
        err_en = 1'b1;
        err_adr = 32'h8;
        for (n = 0; n < 40 && !(ins_valid_o && ins_adr_o == 32'h8); n++) step(1);
        checks++;
        if (!ins_valid_o || {ins_err_o, ins_adr_o, ins_o} !== {1'b1, 32'h8, 32'h0})
            $display("FAIL err_word: valid=%b err=%b adr=%h ins=%h, expected 1 1 00000008 00000000",
                     ins_valid_o, ins_err_o, ins_adr_o, ins_o);
        else passed++;
        step(1);
        for (n = 0; n < 20 && !ins_valid_o; n++) step(1);
        checks++;
        if (!ins_valid_o || {ins_err_o, ins_adr_o, ins_o} !== {1'b0, 32'hC, 32'hC})
            $display("FAIL err_next: valid=%b err=%b adr=%h ins=%h, expected 1 0 0000000c 0000000c",
                     ins_valid_o, ins_err_o, ins_adr_o, ins_o);
        else passed++;
        step(4);
    endtask

    task automatic test_wrap_reset();
        int n;
        do_reset();
        ins_ready_i = 1'b1;
        step(1);
        redirect_adr_i = 32'hFFFF_FFFC;
        redirect_i = 1'b1;
        step(1);
        redirect_i = 1'b0;
        for (n = 0; n < 40 && req_log.size() < 3; n++) step(1);
        checks++;
        if (req_log.size() < 3 || req_log[1] !== 32'hFFFF_FFFC || req_log[2] !== 32'h0)
            $display("FAIL wrap: got %h %h, expected fffffffc 00000000",
                     (req_log.size() > 1) ? req_log[1] : 32'hx,
                     (req_log.size() > 2) ? req_log[2] : 32'hx);
        else passed++;
        for (n = 0; n < 20 && !wb_cyc_o; n++) step(1);
        checks++;
        if (wb_cyc_o !== 1'b1)
            $display("FAIL mid_setup: cyc=%b, expected 1", wb_cyc_o);
        else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({wb_cyc_o, wb_stb_o, ins_valid_o} !== 3'b000)
            $display("FAIL async_rst: cyc=%b stb=%b valid=%b, expected 0 0 0",
                     wb_cyc_o, wb_stb_o, ins_valid_o);
        else passed++;
        @(negedge clk);
        req_log.delete();
        #2;
        rst_n = 1'b1;
        step(1);
        checks++;
        if (wb_cyc_o !== 1'b1 || wb_adr_o !== 32'h0)
            $display("FAIL restart: cyc=%b adr=%h, expected 1 00000000", wb_cyc_o, wb_adr_o);
        else passed++;
        step(8);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_req();
        test_redirect_ack_pop();
        test_err();
        test_wrap_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
